way_data_ram_ctrl: RTL and testbench
====================================

# way_data_ram_ctrl

Controller that shares one dcache way data RAM between three requesters: line refill, LSU store and LSU load. It arbitrates the single write port between two-beat half-line refills and word stores, and issues load reads on the read port. Loads that collide with an in-flight write to the same RAM entry are held back and replayed, so a load never returns stale or torn data. It sits between the dcache miss/store pipeline and the way data RAM, whose write port takes an address, a half-enable (10 = low half-line, 11 = high half-line, 0x = single word with strobe), strobes and data, and whose read port returns a word one cycle after the read.

## Interface
Parameters:
- AWT, 32, address width
- WORD_SEL, 4, word-select field width
- ENTRY_SEL, 7, line-index width
- HALF_LINE_DWT, 256, half-line data width
- LSU_DC_DWT, 32, word width
- LSU_DC_SWT, 4, word byte-strobe width
- STARVE_MAX, 4, consecutive lost store arbitrations before the store is forced to win (1..15)

Ports:
- clk_i in 1 clock
- rst_i in 1 reset. One clock; reset is synchronous and active-high.
- refill_valid_i in 1 refill line request
- refill_ready_o out 1 refill consumed, pulsed in the high-half write cycle
- refill_addr_i in AWT line-aligned refill address
- refill_data_i in 2*HALF_LINE_DWT full line; [HALF_LINE_DWT-1:0] is the low half
- refill_done_o out 1 registered 1-cycle pulse after a refill completes
- st_valid_i in 1 store request
- st_ready_o out 1 store accepted and written this cycle
- st_addr_i in AWT store address
- st_strobe_i in LSU_DC_SWT store byte strobes
- st_data_i in LSU_DC_DWT store data
- ld_valid_i in 1 load request
- ld_ready_o out 1 load accepted this cycle
- ld_addr_i in AWT load address
- ld_rvalid_o out 1 load data valid
- ld_rdata_o out LSU_DC_DWT load data
- ram_wr_en_o out 1 RAM write enable
- ram_wr_half_en_o out 2 RAM write half-enable
- ram_wr_addr_o out AWT RAM write address
- ram_wr_strobe_o out LSU_DC_SWT RAM word strobes
- ram_wr_data_o out HALF_LINE_DWT RAM write data
- ram_rd_en_o out 1 RAM read enable
- ram_rd_addr_o out AWT RAM read address
- ram_rd_wr_conflict_i in 1 conflict flag from the RAM
- ram_rd_word_i in LSU_DC_DWT word from the RAM

## Operation
Address fields: line index = addr[ENTRY_SEL+WORD_SEL+1:WORD_SEL+2]; half = addr[WORD_SEL+1]; word = addr[WORD_SEL:2].

FSM states:
- IDLE
  - Refill wins when refill_valid_i and either no store is valid or starve_cnt < STARVE_MAX.
  - On a refill win: low-half write (half_en=10, data = low half, addr = refill_addr_i); go to RF_HI.
  - Otherwise, if st_valid_i: word write (half_en=00, data = {8{st_data_i}} replicated across the half-line, addr = st_addr_i, strobe = st_strobe_i); st_ready_o=1.
- RF_HI
  - High-half write (half_en=11, data = high half); refill_ready_o=1; go to IDLE. refill_done_o=1 next cycle.
  - st_ready_o=0 throughout.

Starvation counter starve_cnt (4 bits):
- Increments when st_valid_i is high in IDLE and refill wins; saturates.
- Clears on every store accept.

Load path:
- ram_rd_en_o = ld_valid_i; ram_rd_addr_o = ld_addr_i.
- Hazard = ram_rd_wr_conflict_i | (ram_wr_en_o & same line index & same half as the write). Refill writes use half 0 in IDLE and half 1 in RF_HI.
- ld_ready_o = ld_valid_i & ~hazard. A held load stays presented by the requester and reissues the next cycle.
- ld_rvalid_o is registered: high the cycle after ld_ready_o. ld_rdata_o = ram_rd_word_i.

Reset:
- Clears FSM to IDLE, starve_cnt=0, ld_rvalid_o=0, refill_done_o=0.
- All ram_* enables and all ready outputs are 0 while rst_i is high.
- Reset asserted while in RF_HI abandons the refill. No refill_ready_o is given; the requester retries the whole line.

## Timing
- Write outputs, st_ready_o, refill_ready_o and ld_ready_o are combinational from the current state and inputs.
- Store latency: written in the same cycle it is accepted.
- Refill occupancy: exactly 2 consecutive cycles (low half, then high half). refill_done_o follows 1 cycle after the high-half write.
- Load latency: 1 cycle from accept to ld_rvalid_o. Each hazard cycle adds 1 cycle.
- Requesters hold valid, address and data stable until their ready is seen.
- Simultaneous store and refill in RF_HI: the store waits and starve_cnt is unchanged.

## Test plan
- Store only: st_addr=0x0000_0044, strobe=0xF, data=0xDEADBEEF -> same cycle ram_wr_half_en=00, strobe 0xF, st_ready_o=1. A later load of 0x44 -> ld_rdata_o=0xDEADBEEF, 1 cycle after accept.
- Refill line at 0x80: cycle0 half_en=10, cycle1 half_en=11 with refill_ready_o=1, cycle2 refill_done_o=1.
- Load of 0x84 issued during the refill cycle0 -> ld_ready_o=0. Accepted in cycle1 only if its half differs from the high half, else in cycle2. Returns refilled data.
- Back-to-back refill_valid_i with continuous st_valid_i, STARVE_MAX=4 -> store accepted after 4 lost IDLE arbitrations. starve_cnt then 0.
- rst_i pulsed in RF_HI -> next cycle IDLE, no refill_ready_o, no refill_done_o, ld_rvalid_o=0.
- Load to a different line during a refill write -> no stall; ld_rvalid_o the next cycle.

Source files
------------

// File: rtl/way_data_ram_ctrl_if.sv
// Bundle of refill, store, load and way data RAM signals around the
// way data RAM controller. The slave modport is the controller's view;
// the master modport is the requesters' and RAM's view.
interface way_data_ram_ctrl_if #(
  parameter int AWT           = 32,
  parameter int HALF_LINE_DWT = 256,
  parameter int LSU_DC_DWT    = 32,
  parameter int LSU_DC_SWT    = 4
) ();

  // refill requester
  logic                       refill_valid_i;
  logic                       refill_ready_o;
  logic [AWT-1:0]             refill_addr_i;
  logic [2*HALF_LINE_DWT-1:0] refill_data_i;
  logic                       refill_done_o;

  // store requester
  logic                       st_valid_i;
  logic                       st_ready_o;
  logic [AWT-1:0]             st_addr_i;
  logic [LSU_DC_SWT-1:0]      st_strobe_i;
  logic [LSU_DC_DWT-1:0]      st_data_i;

  // load requester
  logic                       ld_valid_i;
  logic                       ld_ready_o;
  logic [AWT-1:0]             ld_addr_i;
  logic                       ld_rvalid_o;
  logic [LSU_DC_DWT-1:0]      ld_rdata_o;

  // way data RAM
  logic                       ram_wr_en_o;
  logic [1:0]                 ram_wr_half_en_o;
  logic [AWT-1:0]             ram_wr_addr_o;
  logic [LSU_DC_SWT-1:0]      ram_wr_strobe_o;
  logic [HALF_LINE_DWT-1:0]   ram_wr_data_o;
  logic                       ram_rd_en_o;
  logic [AWT-1:0]             ram_rd_addr_o;
  logic                       ram_rd_wr_conflict_i;
  logic [LSU_DC_DWT-1:0]      ram_rd_word_i;

  modport slave (
    input  refill_valid_i, refill_addr_i, refill_data_i,
    output refill_ready_o, refill_done_o,
    input  st_valid_i, st_addr_i, st_strobe_i, st_data_i,
    output st_ready_o,
    input  ld_valid_i, ld_addr_i,
    output ld_ready_o, ld_rvalid_o, ld_rdata_o,
    output ram_wr_en_o, ram_wr_half_en_o, ram_wr_addr_o, ram_wr_strobe_o, ram_wr_data_o,
    output ram_rd_en_o, ram_rd_addr_o,
    input  ram_rd_wr_conflict_i, ram_rd_word_i
  );

  modport master (
    output refill_valid_i, refill_addr_i, refill_data_i,
    input  refill_ready_o, refill_done_o,
    output st_valid_i, st_addr_i, st_strobe_i, st_data_i,
    input  st_ready_o,
    output ld_valid_i, ld_addr_i,
    input  ld_ready_o, ld_rvalid_o, ld_rdata_o,
    input  ram_wr_en_o, ram_wr_half_en_o, ram_wr_addr_o, ram_wr_strobe_o, ram_wr_data_o,
    input  ram_rd_en_o, ram_rd_addr_o,
    output ram_rd_wr_conflict_i, ram_rd_word_i
  );

endinterface

// File: rtl/way_data_ram_ctrl.sv
// Way data RAM controller: arbitrates the single write port between
// two-beat half-line refills and word stores (with store starvation
// protection), and issues load reads, holding back any load whose RAM
// entry (line index + half) is being written in the same cycle.
module way_data_ram_ctrl #(
  parameter int AWT           = 32,
  parameter int WORD_SEL      = 4,
  parameter int ENTRY_SEL     = 7,
  parameter int HALF_LINE_DWT = 256,
  parameter int LSU_DC_DWT    = 32,
  parameter int LSU_DC_SWT    = 4,
  parameter int STARVE_MAX    = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  way_data_ram_ctrl_if.slave bus
);

  localparam int LINE_LO  = WORD_SEL + 2;
  localparam int LINE_HI  = ENTRY_SEL + WORD_SEL + 1;
  localparam int HALF_BIT = WORD_SEL + 1;
  localparam int REP      = HALF_LINE_DWT / LSU_DC_DWT;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    RF_HI = 1'b1
  } state_t;

  state_t                   state_r;
  state_t                   state_nxt_s;
  logic [3:0]               starve_cnt_r;
  logic                     ld_rvalid_r;
  logic                     refill_done_r;

  logic                     refill_win_s;
  logic                     wr_en_s;
  logic [1:0]               wr_half_en_s;
  logic [AWT-1:0]           wr_addr_s;
  logic [LSU_DC_SWT-1:0]    wr_strobe_s;
  logic [HALF_LINE_DWT-1:0] wr_data_s;
  logic                     wr_half_s;
  logic                     st_ready_s;
  logic                     refill_ready_s;
  logic                     hazard_s;
  logic                     ld_ready_s;
  logic                     rd_en_s;

  // Write-port arbitration, next state and write-port drive.
  always_comb begin
    state_nxt_s    = state_r;
    refill_win_s   = 1'b0;
    wr_en_s        = 1'b0;
    wr_half_en_s   = 2'b00;
    wr_addr_s      = {AWT{1'b0}};
    wr_strobe_s    = {LSU_DC_SWT{1'b0}};
    wr_data_s      = {HALF_LINE_DWT{1'b0}};
    wr_half_s      = 1'b0;
    st_ready_s     = 1'b0;
    refill_ready_s = 1'b0;
    if (rst_i) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          // A waiting store only yields while it has not lost too often.
          refill_win_s = bus.refill_valid_i &
                         (~bus.st_valid_i | (starve_cnt_r < 4'(STARVE_MAX)));
          if (refill_win_s) begin
            wr_en_s      = 1'b1;
            wr_half_en_s = 2'b10;
            wr_addr_s    = bus.refill_addr_i;
            wr_strobe_s  = {LSU_DC_SWT{1'b1}};
            wr_data_s    = bus.refill_data_i[HALF_LINE_DWT-1:0];
            wr_half_s    = 1'b0;
            state_nxt_s  = RF_HI;
          end else if (bus.st_valid_i) begin
            wr_en_s      = 1'b1;
            wr_half_en_s = 2'b00;
            wr_addr_s    = bus.st_addr_i;
            wr_strobe_s  = bus.st_strobe_i;
            wr_data_s    = {REP{bus.st_data_i}};
            wr_half_s    = bus.st_addr_i[HALF_BIT];
            st_ready_s   = 1'b1;
          end else begin
            wr_en_s = 1'b0;
          end
        end
        RF_HI: begin
          wr_en_s        = 1'b1;
          wr_half_en_s   = 2'b11;
          wr_addr_s      = bus.refill_addr_i;
          wr_strobe_s    = {LSU_DC_SWT{1'b1}};
          wr_data_s      = bus.refill_data_i[2*HALF_LINE_DWT-1:HALF_LINE_DWT];
          wr_half_s      = 1'b1;
          refill_ready_s = 1'b1;
          state_nxt_s    = IDLE;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // Load hazard: RAM-reported conflict or a write to the same entry this cycle.
  always_comb begin
    hazard_s = bus.ram_rd_wr_conflict_i |
               (wr_en_s &
                (bus.ld_addr_i[LINE_HI:LINE_LO] == wr_addr_s[LINE_HI:LINE_LO]) &
                (bus.ld_addr_i[HALF_BIT] == wr_half_s));
    if (rst_i) begin
      rd_en_s    = 1'b0;
      ld_ready_s = 1'b0;
    end else begin
      rd_en_s    = bus.ld_valid_i;
      ld_ready_s = bus.ld_valid_i & ~hazard_s;
    end
  end

  // State, starvation counter and registered pulse outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= IDLE;
      starve_cnt_r  <= 4'd0;
      ld_rvalid_r   <= 1'b0;
      refill_done_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      ld_rvalid_r   <= ld_ready_s;
      refill_done_r <= refill_ready_s;
      if (st_ready_s) begin
        starve_cnt_r <= 4'd0;
      end else if (refill_win_s && bus.st_valid_i && (starve_cnt_r != 4'hF)) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end
  end

  assign bus.ram_wr_en_o      = wr_en_s;
  assign bus.ram_wr_half_en_o = wr_half_en_s;
  assign bus.ram_wr_addr_o    = wr_addr_s;
  assign bus.ram_wr_strobe_o  = wr_strobe_s;
  assign bus.ram_wr_data_o    = wr_data_s;
  assign bus.ram_rd_en_o      = rd_en_s;
  assign bus.ram_rd_addr_o    = bus.ld_addr_i;
  assign bus.st_ready_o       = st_ready_s;
  assign bus.refill_ready_o   = refill_ready_s;
  assign bus.refill_done_o    = refill_done_r;
  assign bus.ld_ready_o       = ld_ready_s;
  assign bus.ld_rvalid_o      = ld_rvalid_r;
  assign bus.ld_rdata_o       = bus.ram_rd_word_i;

endmodule

// File: tb/tb_way_data_ram_ctrl.sv
// Bench for way_data_ram_ctrl: behavioural RAM, golden word memory fed from
// observed handshakes, load-data scoreboard, directed and random traffic.
module tb_way_data_ram_ctrl;

  localparam int AWT = 32, WORD_SEL = 4, ENTRY_SEL = 7;
  localparam int HW = 256, DW = 32, SW = 4, STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  way_data_ram_ctrl_if #(.AWT(AWT), .HALF_LINE_DWT(HW), .LSU_DC_DWT(DW), .LSU_DC_SWT(SW)) bus ();

  way_data_ram_ctrl #(
    .AWT(AWT), .WORD_SEL(WORD_SEL), .ENTRY_SEL(ENTRY_SEL), .HALF_LINE_DWT(HW),
    .LSU_DC_DWT(DW), .LSU_DC_SWT(SW), .STARVE_MAX(STARVE_MAX)
  ) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int total = 0;
  int bad = 0;
  logic [31:0] ram_mem [0:2047];
  logic [31:0] gold [0:2047];
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Behavioural way data RAM: registered read (old data), half-line or strobed word write.
  always @(posedge clk) begin
    if (bus.ram_rd_en_o) bus.ram_rd_word_i <= ram_mem[bus.ram_rd_addr_o[12:2]];
    if (bus.ram_wr_en_o) begin
      if (bus.ram_wr_half_en_o[1]) begin
        for (int w = 0; w < 8; w++)
          ram_mem[{bus.ram_wr_addr_o[12:6], bus.ram_wr_half_en_o[0], 3'(w)}] = bus.ram_wr_data_o[w*32 +: 32];
      end else begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_wr_strobe_o[b])
            ram_mem[bus.ram_wr_addr_o[12:2]][b*8 +: 8] =
              bus.ram_wr_data_o[bus.ram_wr_addr_o[4:2]*32 + b*8 +: 8];
      end
    end
  end

  // Reference model: apply accepted writes to the golden memory, then queue the load's expected word.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.st_valid_i && bus.st_ready_o)
        for (int b = 0; b < 4; b++)
          if (bus.st_strobe_i[b]) gold[bus.st_addr_i[12:2]][b*8 +: 8] = bus.st_data_i[b*8 +: 8];
      if (bus.refill_ready_o)
        for (int w = 0; w < 16; w++)
          gold[{bus.refill_addr_i[12:6], 4'(w)}] = bus.refill_data_i[w*32 +: 32];
      if (bus.ld_valid_i && bus.ld_ready_o) exp_q.push_back(gold[bus.ld_addr_i[12:2]]);
    end
  end

  // Monitor: every returned load word is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.ld_rvalid_o) begin
      if (exp_q.size() == 0) check("rvalid_unexpected", 512'd1, 512'd0);
      else check("load_data", bus.ld_rdata_o, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  logic [511:0] rf;
  int acc_cyc, lows;
  logic st_acc, rf_acc, ld_acc;

  initial begin
    for (int i = 0; i < 2048; i++) begin ram_mem[i] = 32'd0; gold[i] = 32'd0; end
    bus.ram_rd_word_i = 32'd0;
    bus.ram_rd_wr_conflict_i = 1'b0;
    bus.refill_addr_i = 32'd0; bus.refill_data_i = 512'd0;
    bus.st_addr_i = 32'd0; bus.st_strobe_i = 4'd0; bus.st_data_i = 32'd0;
    bus.ld_addr_i = 32'd0;
    // requests presented during reset must be ignored
    rst = 1'b1;
    bus.refill_valid_i = 1'b1; bus.st_valid_i = 1'b1; bus.ld_valid_i = 1'b1;
    sample();
    check("rst_gating", {bus.ram_wr_en_o, bus.ram_rd_en_o, bus.st_ready_o, bus.refill_ready_o, bus.ld_ready_o}, 512'd0);
    sample();
    check("rst_pulses", {bus.ld_rvalid_o, bus.refill_done_o}, 512'd0);
    step();
    rst = 1'b0;
    bus.refill_valid_i = 1'b0; bus.st_valid_i = 1'b0; bus.ld_valid_i = 1'b0;

    // store 0x44 then load it back
    bus.st_valid_i = 1'b1; bus.st_addr_i = 32'h44; bus.st_strobe_i = 4'hF; bus.st_data_i = 32'hDEADBEEF;
    sample();
    check("st_ready", bus.st_ready_o, 512'd1);
    check("st_wr", {bus.ram_wr_en_o, bus.ram_wr_half_en_o, bus.ram_wr_strobe_o, bus.ram_wr_addr_o}, {1'b1, 2'b00, 4'hF, 32'h44});
    check("st_data_rep", bus.ram_wr_data_o, {8{32'hDEADBEEF}});
    step();
    bus.st_valid_i = 1'b0; bus.ld_valid_i = 1'b1; bus.ld_addr_i = 32'h44;
    sample();
    check("ld44_ready", bus.ld_ready_o, 512'd1);
    step();
    bus.ld_valid_i = 1'b0;
    sample();
    check("ld44_rvalid", bus.ld_rvalid_o, 512'd1);
    check("ld44_data", bus.ld_rdata_o, 32'hDEADBEEF);

    // refill line 0x80 with a load of 0x84 presented from cycle 0
    step();
    rf = rand_line();
    bus.refill_valid_i = 1'b1; bus.refill_addr_i = 32'h80; bus.refill_data_i = rf;
    bus.ld_valid_i = 1'b1; bus.ld_addr_i = 32'h84;
    sample();
    check("rf_c0_wr", {bus.ram_wr_en_o, bus.ram_wr_half_en_o, bus.ram_wr_addr_o}, {1'b1, 2'b10, 32'h80});
    check("rf_c0_data", bus.ram_wr_data_o, rf[255:0]);
    check("rf_c0_flags", {bus.refill_ready_o, bus.refill_done_o, bus.ld_ready_o}, 512'd0);
    step();
    sample();
    check("rf_c1_half", bus.ram_wr_half_en_o, 2'b11);
    check("rf_c1_data", bus.ram_wr_data_o, rf[511:256]);
    check("rf_c1_flags", {bus.refill_ready_o, bus.refill_done_o, bus.ld_ready_o}, 3'b101);
    step();
    bus.refill_valid_i = 1'b0; bus.ld_valid_i = 1'b0;
    sample();
    check("rf_c2_done", {bus.refill_done_o, bus.ld_rvalid_o}, 2'b11);
    check("rf_ld84_data", bus.ld_rdata_o, rf[63:32]);

    // refill 0xC0: other-line load in cycle 0, same-line high-half load from cycle 1
    step();
    rf = rand_line();
    bus.refill_valid_i = 1'b1; bus.refill_addr_i = 32'hC0; bus.refill_data_i = rf;
    bus.ld_valid_i = 1'b1; bus.ld_addr_i = 32'h1000;
    sample();
    check("rf2_c0_other_ld", bus.ld_ready_o, 512'd1);
    step();
    bus.ld_addr_i = 32'hE0;
    sample();
    check("rf2_c1_rvalid", bus.ld_rvalid_o, 512'd1);
    check("rf2_c1_hold", bus.ld_ready_o, 512'd0);
    step();
    bus.refill_valid_i = 1'b0;
    sample();
    check("rf2_c2", {bus.ld_ready_o, bus.refill_done_o}, 2'b11);
    step();
    bus.ld_valid_i = 1'b0;
    sample();
    check("rf2_lde0_data", bus.ld_rdata_o, rf[287:256]);

    // store/load to the same entry: load held for the store cycle
    step();
    bus.st_valid_i = 1'b1; bus.st_addr_i = 32'h48; bus.st_strobe_i = 4'b0011; bus.st_data_i = 32'h12345678;
    bus.ld_valid_i = 1'b1; bus.ld_addr_i = 32'h48;
    sample();
    check("st_ld_hazard", {bus.st_ready_o, bus.ld_ready_o}, 2'b10);
    step();
    bus.st_valid_i = 1'b0;
    sample();
    check("st_ld_replay", bus.ld_ready_o, 512'd1);
    step();
    bus.ld_valid_i = 1'b0;
    sample();
    check("st_ld_data", bus.ld_rdata_o, 32'h00005678);

    // starvation: continuous refills against a waiting store
    step();
    rf = rand_line();
    bus.refill_valid_i = 1'b1; bus.refill_addr_i = 32'h200; bus.refill_data_i = rf;
    bus.st_valid_i = 1'b1; bus.st_addr_i = 32'h300; bus.st_strobe_i = 4'hF; bus.st_data_i = 32'hCAFEF00D;
    acc_cyc = -1; lows = 0;
    for (int c = 0; c < 40; c++) begin
      sample();
      if (bus.st_ready_o) begin acc_cyc = c; break; end
      if (bus.ram_wr_half_en_o == 2'b10) lows++;
      step();
    end
    check("starve_accept_cycle", 32'(acc_cyc), 32'(2 * STARVE_MAX));
    check("starve_lost_arbs", 32'(lows), 32'(STARVE_MAX));
    step();
    bus.st_data_i = 32'h0BADF00D;
    sample();
    check("starve_cleared", {bus.ram_wr_half_en_o, bus.st_ready_o}, {2'b10, 1'b0});
    step();
    sample();
    check("rfhi_store_waits", {bus.refill_ready_o, bus.st_ready_o}, 2'b10);
    step();
    bus.refill_valid_i = 1'b0;
    sample();
    check("store_after_rf", bus.st_ready_o, 512'd1);
    step();
    bus.st_valid_i = 1'b0;

    // reset while in RF_HI abandons the refill
    rf = rand_line();
    bus.refill_valid_i = 1'b1; bus.refill_addr_i = 32'h400; bus.refill_data_i = rf;
    sample();
    check("rstrf_c0", bus.ram_wr_half_en_o, 2'b10);
    step();
    rst = 1'b1;
    sample();
    check("rstrf_gated", {bus.ram_wr_en_o, bus.refill_ready_o, bus.st_ready_o, bus.ld_ready_o}, 512'd0);
    step();
    rst = 1'b0;
    sample();
    check("rstrf_after", {bus.refill_done_o, bus.ld_rvalid_o, bus.refill_ready_o, bus.ram_wr_half_en_o}, {4'b0000, 1'b0, 2'b10});
    step();
    sample();
    check("rstrf_retry_ready", bus.refill_ready_o, 512'd1);
    step();
    bus.refill_valid_i = 1'b0;
    sample();
    check("rstrf_retry_done", bus.refill_done_o, 512'd1);

    // random traffic over four lines with occasional RAM conflicts
    for (int c = 0; c < 3000; c++) begin
      sample();
      st_acc = bus.st_valid_i & bus.st_ready_o;
      rf_acc = bus.refill_ready_o;
      ld_acc = bus.ld_valid_i & bus.ld_ready_o;
      step();
      if (st_acc) bus.st_valid_i = 1'b0;
      if (rf_acc) bus.refill_valid_i = 1'b0;
      if (ld_acc) bus.ld_valid_i = 1'b0;
      if (!bus.st_valid_i && $urandom_range(0, 2) == 0) begin
        bus.st_valid_i = 1'b1;
        bus.st_addr_i = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
        bus.st_strobe_i = 4'($urandom_range(1, 15));
        bus.st_data_i = $urandom;
      end
      if (!bus.refill_valid_i && $urandom_range(0, 11) == 0) begin
        bus.refill_valid_i = 1'b1;
        bus.refill_addr_i = 32'($urandom_range(0, 3)) << 6;
        bus.refill_data_i = rand_line();
      end
      if (!bus.ld_valid_i && $urandom_range(0, 1) == 0) begin
        bus.ld_valid_i = 1'b1;
        bus.ld_addr_i = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      end
      bus.ram_rd_wr_conflict_i = ($urandom_range(0, 7) == 0);
    end
    sample();
    step();
    bus.st_valid_i = 1'b0; bus.refill_valid_i = 1'b0; bus.ld_valid_i = 1'b0;
    bus.ram_rd_wr_conflict_i = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
